// File: rtl/lieat_exu_com_csr_arb.sv
// rtl/lieat_exu_com_csr_arb.sv - commit-stage CSR port arbiter (COM vs TRP with lock and aging; CSR_ARB_RR_EN selects round-robin)
module lieat_exu_com_csr_arb #(
    parameter int XLEN       = 32,
    parameter int CSR_IDX    = 12,
    parameter int STARVE_LIM = 4,
    parameter int CNT_W      = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               com_req_valid,
    output logic               com_req_ready,
    input  logic               com_req_write,
    input  logic [CSR_IDX-1:0] com_req_idx,
    input  logic [XLEN-1:0]    com_req_wdata,
    output logic               com_rsp_valid,
    output logic [XLEN-1:0]    com_rsp_data,
    input  logic               trp_req_valid,
    output logic               trp_req_ready,
    input  logic               trp_req_write,
    input  logic               trp_req_lock,
    input  logic [CSR_IDX-1:0] trp_req_idx,
    input  logic [XLEN-1:0]    trp_req_wdata,
    output logic               trp_rsp_valid,
    output logic [XLEN-1:0]    trp_rsp_data,
    output logic               csr_ena,
    output logic               csr_write,
    output logic               csr_read,
    output logic [CSR_IDX-1:0] csr_idx,
    output logic [XLEN-1:0]    csr_wdata,
    input  logic [XLEN-1:0]    csr_rdata
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             com_grant;
    logic             trp_grant;

`ifdef CSR_ARB_RR_EN
    // set when TRP won the most recent grant; reset value lets COM win first
    logic last_trp;
    logic last_trp_nxt;
`endif

    // arbitration, next state and starvation counter update
    always_comb begin
        com_grant = 1'b0;
        trp_grant = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;
`ifdef CSR_ARB_RR_EN
        last_trp_nxt = last_trp;
`endif
        case (state)
            ST_IDLE: begin
                if (com_req_valid && trp_req_valid) begin
`ifdef CSR_ARB_RR_EN
                    if (last_trp) begin
                        com_grant = 1'b1;
                    end else begin
                        trp_grant = 1'b1;
                    end
`else
                    if (cnt < CNT_W'(STARVE_LIM)) begin
                        com_grant = 1'b1;
                        if (cnt != {CNT_W{1'b1}}) begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end else begin
                        trp_grant = 1'b1;
                    end
`endif
                end else if (com_req_valid) begin
                    com_grant = 1'b1;
                end else if (trp_req_valid) begin
                    trp_grant = 1'b1;
                end
                // TRP is not waiting (or just got served), so its age restarts
                if (!trp_req_valid || trp_grant) begin
                    cnt_nxt = '0;
                end
                if (trp_grant && trp_req_lock) begin
                    state_nxt = ST_LOCK;
                end
            end
            ST_LOCK: begin
                // port stays with TRP until it issues an unlocked access
                trp_grant = trp_req_valid;
                cnt_nxt   = '0;
                if (trp_grant && !trp_req_lock) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
`ifdef CSR_ARB_RR_EN
        cnt_nxt = '0;
        if (com_grant) begin
            last_trp_nxt = 1'b0;
        end else if (trp_grant) begin
            last_trp_nxt = 1'b1;
        end
`endif
    end

    assign com_req_ready = com_grant;
    assign trp_req_ready = trp_grant;

    // CSR port drive: winner's payload, everything quiet when nobody is granted
    always_comb begin
        csr_ena   = com_grant | trp_grant;
        csr_read  = com_grant | trp_grant;
        csr_write = 1'b0;
        csr_idx   = '0;
        csr_wdata = '0;
        if (com_grant) begin
            csr_write = com_req_write;
            csr_idx   = com_req_idx;
            csr_wdata = com_req_wdata;
        end else if (trp_grant) begin
            csr_write = trp_req_write;
            csr_idx   = trp_req_idx;
            csr_wdata = trp_req_wdata;
        end
    end

    // state, counter and one-cycle-late read responses
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            com_rsp_valid <= 1'b0;
            com_rsp_data  <= '0;
            trp_rsp_valid <= 1'b0;
            trp_rsp_data  <= '0;
`ifdef CSR_ARB_RR_EN
            last_trp      <= 1'b1;
`endif
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            com_rsp_valid <= com_grant;
            trp_rsp_valid <= trp_grant;
            if (com_grant) begin
                com_rsp_data <= csr_rdata;
            end
            if (trp_grant) begin
                trp_rsp_data <= csr_rdata;
            end
`ifdef CSR_ARB_RR_EN
            last_trp      <= last_trp_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_lieat_exu_com_csr_arb.sv
// tb/tb_lieat_exu_com_csr_arb.sv - self-checking bench for lieat_exu_com_csr_arb (default and CSR_ARB_RR_EN builds)
module tb_lieat_exu_com_csr_arb;

    logic        clock = 1'b0;
    logic        reset;
    logic        com_req_valid, com_req_ready, com_req_write;
    logic [11:0] com_req_idx;
    logic [31:0] com_req_wdata;
    logic        com_rsp_valid;
    logic [31:0] com_rsp_data;
    logic        trp_req_valid, trp_req_ready, trp_req_write, trp_req_lock;
    logic [11:0] trp_req_idx;
    logic [31:0] trp_req_wdata;
    logic        trp_rsp_valid;
    logic [31:0] trp_rsp_data;
    logic        csr_ena, csr_write, csr_read;
    logic [11:0] csr_idx;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lieat_exu_com_csr_arb dut (
        .clock(clock), .reset(reset),
        .com_req_valid(com_req_valid), .com_req_ready(com_req_ready),
        .com_req_write(com_req_write), .com_req_idx(com_req_idx),
        .com_req_wdata(com_req_wdata), .com_rsp_valid(com_rsp_valid),
        .com_rsp_data(com_rsp_data),
        .trp_req_valid(trp_req_valid), .trp_req_ready(trp_req_ready),
        .trp_req_write(trp_req_write), .trp_req_lock(trp_req_lock),
        .trp_req_idx(trp_req_idx), .trp_req_wdata(trp_req_wdata),
        .trp_rsp_valid(trp_rsp_valid), .trp_rsp_data(trp_rsp_data),
        .csr_ena(csr_ena), .csr_write(csr_write), .csr_read(csr_read),
        .csr_idx(csr_idx), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
    );

    typedef struct {
        logic        cv, cw;
        logic [11:0] ci;
        logic [31:0] cd;
        logic        tv, tw, tl;
        logic [11:0] ti;
        logic [31:0] td;
        logic [31:0] rd;
        logic        e_cr, e_tr, e_ena, e_wr;
        logic [11:0] e_idx;
        logic [31:0] e_wd;
        logic        e_crv;
        logic [31:0] e_crd;
        logic        e_trv;
        logic [31:0] e_trd;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        com_req_valid = 0; com_req_write = 0; com_req_idx = '0; com_req_wdata = '0;
        trp_req_valid = 0; trp_req_write = 0; trp_req_lock = 0; trp_req_idx = '0; trp_req_wdata = '0;
        csr_rdata = '0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        reset = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clock); #1;
    endtask

    initial begin
        logic exp_t, prev_t, got;

        //                 cv cw  ci      cd       tv tw tl  ti      td       rd           cr tr en wr idx     wd       crv crd          trv trd
        vecs[0] = '{1, 1, 12'h300, 32'h8,   0, 0, 0, 12'h000, 32'h0,  32'h1800,   1, 0, 1, 1, 12'h300, 32'h8,  0, 32'h0,    0, 32'h0};
        vecs[1] = '{0, 0, 12'h000, 32'h0,   0, 0, 0, 12'h000, 32'h0,  32'hDEAD,   0, 0, 0, 0, 12'h000, 32'h0,  1, 32'h1800, 0, 32'h0};
        vecs[2] = '{0, 0, 12'h000, 32'h0,   1, 0, 0, 12'h342, 32'h55, 32'h77,     0, 1, 1, 0, 12'h342, 32'h55, 0, 32'h1800, 0, 32'h0};
        vecs[3] = '{1, 0, 12'hB00, 32'h3,   0, 0, 0, 12'h000, 32'h0,  32'h1234,   1, 0, 1, 0, 12'hB00, 32'h3,  0, 32'h1800, 1, 32'h77};
        vecs[4] = '{0, 0, 12'h000, 32'h0,   0, 0, 0, 12'h000, 32'h0,  32'h0,      0, 0, 0, 0, 12'h000, 32'h0,  1, 32'h1234, 0, 32'h77};

        // reset state
        reset_dut();
        @(negedge clock);
        chk("rst_com_rsp_valid", com_rsp_valid, 0);
        chk("rst_com_rsp_data", com_rsp_data, 0);
        chk("rst_trp_rsp_valid", trp_rsp_valid, 0);
        chk("rst_trp_rsp_data", trp_rsp_data, 0);
        chk("rst_csr_ena", csr_ena, 0);
        chk("rst_csr_read", csr_read, 0);
        nxt();

        // table-driven single-requester traffic
        for (int i = 0; i < 5; i++) begin
            com_req_valid = vecs[i].cv; com_req_write = vecs[i].cw;
            com_req_idx = vecs[i].ci;   com_req_wdata = vecs[i].cd;
            trp_req_valid = vecs[i].tv; trp_req_write = vecs[i].tw; trp_req_lock = vecs[i].tl;
            trp_req_idx = vecs[i].ti;   trp_req_wdata = vecs[i].td;
            csr_rdata = vecs[i].rd;
            @(negedge clock);
            chk($sformatf("v%0d_com_ready", i), com_req_ready, vecs[i].e_cr);
            chk($sformatf("v%0d_trp_ready", i), trp_req_ready, vecs[i].e_tr);
            chk($sformatf("v%0d_csr_ena", i), csr_ena, vecs[i].e_ena);
            chk($sformatf("v%0d_csr_read", i), csr_read, vecs[i].e_ena);
            chk($sformatf("v%0d_csr_write", i), csr_write, vecs[i].e_wr);
            chk($sformatf("v%0d_csr_idx", i), csr_idx, vecs[i].e_idx);
            chk($sformatf("v%0d_csr_wdata", i), csr_wdata, vecs[i].e_wd);
            chk($sformatf("v%0d_com_rsp_valid", i), com_rsp_valid, vecs[i].e_crv);
            chk($sformatf("v%0d_com_rsp_data", i), com_rsp_data, vecs[i].e_crd);
            chk($sformatf("v%0d_trp_rsp_valid", i), trp_rsp_valid, vecs[i].e_trv);
            chk($sformatf("v%0d_trp_rsp_data", i), trp_rsp_data, vecs[i].e_trd);
            nxt();
        end

        // continuous contention on the same index order: aging or round-robin
        reset_dut();
        com_req_valid = 1; com_req_idx = 12'h300; com_req_wdata = 32'h1;
        trp_req_valid = 1; trp_req_idx = 12'h341; trp_req_wdata = 32'h2;
        csr_rdata = 32'hCAFE;
        prev_t = 0;
        for (int i = 0; i < 10; i++) begin
`ifdef CSR_ARB_RR_EN
            exp_t = (i % 2) == 1;
`else
            exp_t = (i % 5) == 4;
`endif
            @(negedge clock);
            chk($sformatf("cont%0d_com_ready", i), com_req_ready, !exp_t);
            chk($sformatf("cont%0d_trp_ready", i), trp_req_ready, exp_t);
            chk($sformatf("cont%0d_csr_idx", i), csr_idx, exp_t ? 32'h341 : 32'h300);
            if (i > 0) begin
                chk($sformatf("cont%0d_trp_rsp_valid", i), trp_rsp_valid, prev_t);
                chk($sformatf("cont%0d_com_rsp_valid", i), com_rsp_valid, !prev_t);
            end
            prev_t = exp_t;
            nxt();
        end

        // locked ecall sequence with COM pressing throughout
        reset_dut();
        com_req_valid = 1; com_req_idx = 12'h305;
        trp_req_valid = 1; trp_req_write = 1; trp_req_lock = 1;
        trp_req_idx = 12'h341; trp_req_wdata = 32'h80000010;
        csr_rdata = 32'h4444;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clock);
            if (trp_req_ready) begin
                got = 1;
            end else begin
                chk($sformatf("lock_wait%0d_com_ready", i), com_req_ready, 1);
                nxt();
            end
        end
        chk("lock_first_grant", got, 1);
        chk("lock_first_idx", csr_idx, 12'h341);
        chk("lock_first_wdata", csr_wdata, 32'h80000010);
        nxt();
        trp_req_idx = 12'h342; trp_req_wdata = 32'hB; trp_req_lock = 0;
        @(negedge clock);
        chk("lock_second_trp_ready", trp_req_ready, 1);
        chk("lock_second_com_ready", com_req_ready, 0);
        chk("lock_second_idx", csr_idx, 12'h342);
        chk("lock_second_wdata", csr_wdata, 32'hB);
        chk("lock_second_write", csr_write, 1);
        nxt();
        trp_req_valid = 0;
        @(negedge clock);
        chk("lock_after_com_ready", com_req_ready, 1);
        chk("lock_after_trp_rsp_valid", trp_rsp_valid, 1);
        chk("lock_after_trp_rsp_data", trp_rsp_data, 32'h4444);
        nxt();

        // lock stall: TRP owns the port but goes quiet
        reset_dut();
        trp_req_valid = 1; trp_req_lock = 1; trp_req_idx = 12'h341;
        @(negedge clock);
        chk("stall_lock_grant", trp_req_ready, 1);
        nxt();
        trp_req_valid = 0; com_req_valid = 1; com_req_idx = 12'h300;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk($sformatf("stall%0d_com_ready", i), com_req_ready, 0);
            chk($sformatf("stall%0d_csr_ena", i), csr_ena, 0);
            nxt();
        end
        trp_req_valid = 1; trp_req_lock = 0; trp_req_idx = 12'h342;
        @(negedge clock);
        chk("stall_release_trp_ready", trp_req_ready, 1);
        chk("stall_release_com_ready", com_req_ready, 0);
        nxt();
        trp_req_valid = 0;
        @(negedge clock);
        chk("stall_after_com_ready", com_req_ready, 1);
        nxt();

        // reset while locked, one cycle after the locking grant
        reset_dut();
        trp_req_valid = 1; trp_req_lock = 1; trp_req_idx = 12'h341;
        nxt();
        reset = 1; com_req_valid = 1; com_req_idx = 12'h300;
        @(negedge clock);
        chk("rstlock_pending_rsp", trp_rsp_valid, 1);
        chk("rstlock_com_blocked", com_req_ready, 0);
        nxt();
        reset = 0; trp_req_valid = 0; trp_req_lock = 0;
        @(negedge clock);
        chk("rstlock_trp_rsp_valid", trp_rsp_valid, 0);
        chk("rstlock_com_rsp_valid", com_rsp_valid, 0);
        chk("rstlock_com_ready", com_req_ready, 1);
        chk("rstlock_csr_idx", csr_idx, 12'h300);
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
